toggle_activity_monitor: RTL
============================

Name: toggle_activity_monitor

Overview:
- Downstream consumer of the power-experiment sub-circuits: samples the node vector of one sub-circuit (primary inputs, internal nets, output) each cycle and counts per-node switching activity over a programmable window.
- At window end, reduces the per-node counts to a total, a hottest-node index and a saturation flag.
- Emits a single report over a valid/ready handshake to the power-estimation collector.

Parameters:
- NODE_W, 8, number of monitored nodes (bits of node_vec).
- CNT_W, 16, width of each per-node saturating toggle counter.
- WIN_W, 16, width of win_len and of the sample counter.
- Derived (not overridable): IDX_W = $clog2(NODE_W); TOT_W = CNT_W + IDX_W.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- win_len  in  WIN_W  number of toggle-comparison samples after the prime sample; latched on accepted start.
- node_vec_valid  in  1  node_vec carries a sample this cycle.
- node_vec  in  NODE_W  sampled node values.
- busy  out  1  state != IDLE.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  collector accepts the report.
- rpt_total  out  TOT_W  sum of all per-node toggle counts.
- rpt_max_idx  out  IDX_W  index of the node with the highest count (lowest index on ties).
- rpt_max_cnt  out  CNT_W  count of that node.
- rpt_sat  out  1  at least one per-node counter saturated.

Behaviour:
- Reset (sync, rst=1): state IDLE; all counters, prev-sample register and report registers cleared; every output 0. Reset in any state (including mid-ACCUM or REPORT) aborts the run with no report.
- FSM states: IDLE, PRIME, ACCUM, REDUCE, REPORT.
- IDLE:
  - start=1: latch win_len, clear counters and sat, go to PRIME.
  - node_vec_valid is ignored.
- PRIME:
  - First valid sample is stored as prev; no counting.
  - If latched win_len==0, go to REDUCE; otherwise go to ACCUM.
- ACCUM, on each valid sample:
  - diff = node_vec ^ prev.
  - cnt[i] += diff[i], saturating at 2^CNT_W-1; any saturation event sets sat.
  - prev <= node_vec; sample count increments.
  - On the win_len-th accepted sample, go to REDUCE.
  - Invalid cycles change nothing.
- REDUCE: exactly NODE_W cycles, i = 0..NODE_W-1.
  - total += cnt[i]. No overflow is possible at TOT_W.
  - If cnt[i] > max (strict comparison), update max and idx.
  - Then go to REPORT.
- Latency: the last window sample is accepted in cycle t, and rpt_valid rises in cycle t+NODE_W+1.
- REPORT:
  - rpt_valid=1; all rpt_* outputs are held stable until the handshake.
  - Handshake when rpt_valid & rpt_ready: go to IDLE next cycle; rpt_valid drops.
  - rpt_* outputs keep their last values until the next REPORT.
- start is ignored in every state except IDLE, including the cycle of the report handshake.
- node_vec_valid is ignored in REDUCE and REPORT; samples arriving there are dropped and not buffered.

Decomposition:
- Shared package tam_pkg holds:
  - the state enum (IDLE, PRIME, ACCUM, REDUCE, REPORT);
  - the default-parameter constants;
  - the report struct (total, max_idx, max_cnt, sat).
- One sub-module, tam_toggle_bank:
  - NODE_W saturating counters with clear, increment-vector and read-mux inputs;
  - outputs the per-counter saturated flag OR-reduced.
- FSM, sample counter and reduction remain in the top.

Test Plan:
- Full toggle: NODE_W=8, win_len=4; samples 0x00 (prime), 0xFF, 0x00, 0xFF, 0x00 -> rpt_total=32, rpt_max_idx=0, rpt_max_cnt=4, rpt_sat=0; rpt_valid rises 9 cycles after the last sample.
- Single hot node: win_len=3; samples 0x00, 0x20, 0x00, 0x20, with node_vec_valid gaps between them -> rpt_total=3, rpt_max_idx=5, rpt_max_cnt=3.
- Saturation: CNT_W=4, win_len=20, bit0 alternating every sample -> rpt_max_cnt=15, rpt_total=15, rpt_sat=1.
- Backpressure and start filtering:
  - hold rpt_ready=0 for 5 cycles in REPORT, pulsing start and node_vec_valid -> outputs unchanged, no new run;
  - rpt_ready=1 -> IDLE next cycle, busy=0.
- win_len=0: start, then one prime sample -> report with total=0, max_idx=0, max_cnt=0.
- Reset mid-ACCUM: assert rst for 1 cycle after 2 of 4 samples -> all outputs 0, IDLE; a fresh run then reproduces the full-toggle result exactly.

Source files
------------

// File: rtl/tam_pkg.sv
// Shared types and default constants for the toggle activity monitor.
package tam_pkg;

    localparam int unsigned TAM_DEF_NODE_W = 8;
    localparam int unsigned TAM_DEF_CNT_W  = 16;
    localparam int unsigned TAM_DEF_WIN_W  = 16;
    localparam int unsigned TAM_DEF_IDX_W  = $clog2(TAM_DEF_NODE_W);
    localparam int unsigned TAM_DEF_TOT_W  = TAM_DEF_CNT_W + TAM_DEF_IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_ACCUM,
        S_REDUCE,
        S_REPORT
    } tam_state_e;

    // Report record at the default widths.
    typedef struct packed {
        logic [TAM_DEF_TOT_W-1:0] total;
        logic [TAM_DEF_IDX_W-1:0] max_idx;
        logic [TAM_DEF_CNT_W-1:0] max_cnt;
        logic                     sat;
    } tam_rpt_t;

endpackage

// File: rtl/tam_toggle_bank.sv
// Bank of per-node saturating toggle counters with a read mux and a
// sticky per-counter overflow flag, OR-reduced.
module tam_toggle_bank
    import tam_pkg::*;
#(
    parameter int unsigned NODE_W = TAM_DEF_NODE_W,
    parameter int unsigned CNT_W  = TAM_DEF_CNT_W,
    parameter int unsigned IDX_W  = TAM_DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [NODE_W-1:0] inc_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic              sat_o
);

    logic [CNT_W-1:0]  cnt_q [NODE_W];
    logic [NODE_W-1:0] sat_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int unsigned i = 0; i < NODE_W; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NODE_W; i++) begin
                if (inc_i[i]) begin
                    // An increment arriving at full scale is dropped and flagged.
                    if (cnt_q[i] == '1) begin
                        sat_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign sat_o    = |sat_q;

endmodule

// File: rtl/toggle_activity_monitor.sv
// Counts per-node switching activity over a programmable sample window and
// reports total, hottest node and saturation over a valid/ready handshake.
module toggle_activity_monitor
    import tam_pkg::*;
#(
    parameter  int unsigned NODE_W = TAM_DEF_NODE_W,
    parameter  int unsigned CNT_W  = TAM_DEF_CNT_W,
    parameter  int unsigned WIN_W  = TAM_DEF_WIN_W,
    localparam int unsigned IDX_W  = $clog2(NODE_W),
    localparam int unsigned TOT_W  = CNT_W + IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              node_vec_valid,
    input  logic [NODE_W-1:0] node_vec,
    output logic              busy,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [TOT_W-1:0]  rpt_total,
    output logic [IDX_W-1:0]  rpt_max_idx,
    output logic [CNT_W-1:0]  rpt_max_cnt,
    output logic              rpt_sat
);

    tam_state_e        state_q;
    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  smp_q, smp_d;
    logic [NODE_W-1:0] prev_q;
    logic [IDX_W-1:0]  red_q;
    logic [TOT_W-1:0]  tot_q, tot_d;
    logic [CNT_W-1:0]  max_q;
    logic [IDX_W-1:0]  idx_q;

    logic              rpt_valid_q;
    logic [TOT_W-1:0]  rpt_total_q;
    logic [IDX_W-1:0]  rpt_max_idx_q;
    logic [CNT_W-1:0]  rpt_max_cnt_q;
    logic              rpt_sat_q;

    logic [NODE_W-1:0] bank_inc;
    logic              bank_clr;
    logic [CNT_W-1:0]  rd_cnt;
    logic              bank_sat;
    logic              max_hit;
    logic              red_last;

    always_comb begin
        smp_d    = smp_q + WIN_W'(1);
        tot_d    = tot_q + TOT_W'(rd_cnt);
        max_hit  = rd_cnt > max_q;
        red_last = red_q == IDX_W'(NODE_W - 1);
        bank_clr = (state_q == S_IDLE) && start;
        bank_inc = '0;
        if (state_q == S_ACCUM && node_vec_valid) begin
            bank_inc = node_vec ^ prev_q;
        end
    end

    tam_toggle_bank #(
        .NODE_W (NODE_W),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (bank_clr),
        .inc_i    (bank_inc),
        .rd_idx_i (red_q),
        .rd_cnt_o (rd_cnt),
        .sat_o    (bank_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_q         <= '0;
            smp_q         <= '0;
            prev_q        <= '0;
            red_q         <= '0;
            tot_q         <= '0;
            max_q         <= '0;
            idx_q         <= '0;
            rpt_valid_q   <= 1'b0;
            rpt_total_q   <= '0;
            rpt_max_idx_q <= '0;
            rpt_max_cnt_q <= '0;
            rpt_sat_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        win_q   <= win_len;
                        smp_q   <= '0;
                        red_q   <= '0;
                        tot_q   <= '0;
                        max_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (node_vec_valid) begin
                        prev_q  <= node_vec;
                        state_q <= (win_q == '0) ? S_REDUCE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (node_vec_valid) begin
                        prev_q <= node_vec;
                        smp_q  <= smp_d;
                        if (smp_d == win_q) begin
                            state_q <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    tot_q <= tot_d;
                    red_q <= red_q + IDX_W'(1);
                    if (max_hit) begin
                        max_q <= rd_cnt;
                        idx_q <= red_q;
                    end
                    // Final node folds straight into the report registers.
                    if (red_last) begin
                        rpt_total_q   <= tot_d;
                        rpt_max_cnt_q <= max_hit ? rd_cnt : max_q;
                        rpt_max_idx_q <= max_hit ? red_q : idx_q;
                        rpt_sat_q     <= bank_sat;
                        rpt_valid_q   <= 1'b1;
                        state_q       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = state_q != S_IDLE;
    assign rpt_valid   = rpt_valid_q;
    assign rpt_total   = rpt_total_q;
    assign rpt_max_idx = rpt_max_idx_q;
    assign rpt_max_cnt = rpt_max_cnt_q;
    assign rpt_sat     = rpt_sat_q;

endmodule
